// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch sequencer and the program counter.
package cpu_pkg;

  typedef enum logic [2:0] {
    RST_WAIT,
    FETCH,
    EXEC1,
    EXEC2,
    HALTED
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [3:0]  BE_WORD      = 4'hF;

endpackage

// File: rtl/avalon_req_hold.sv
// Registered Avalon request fields (address, byteenable, writedata).
// Loaded at the start of a transfer and frozen until the sequencer lets go.
module avalon_req_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] address_next,
  input  logic [3:0]  byteenable_next,
  input  logic [31:0] writedata_next,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
    end else if (load) begin
      address    <= address_next;
      byteenable <= byteenable_next;
      writedata  <= writedata_next;
    end else if (clear) begin
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences each instruction through FETCH -> EXEC1 -> EXEC2 on the CPU's
// single Avalon master port; all bus outputs and strobes are registered.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_address,
  input  logic               halt,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_be,
  output logic [31:0]        address,
  output logic               read,
  output logic               write,
  output logic [31:0]        writedata,
  output logic [3:0]         byteenable,
  input  logic               waitrequest,
  input  logic [31:0]        readdata,
  output logic [31:0]        instr,
  output logic [31:0]        load_data,
  output logic               fetch,
  output logic               exec1,
  output logic               exec2,
  output logic               active,
  output logic [COUNT_W-1:0] instr_count
);
  import cpu_pkg::*;

  seq_state_t  state, state_d;
  logic        rd_d, wr_d, load_req, bus_done;
  logic [31:0] addr_d, wdata_d;
  logic [3:0]  be_d;

  assign bus_done = (read | write) & ~waitrequest;

  // Next-state also decides the next registered bus request, so a transfer
  // starts on the first cycle of FETCH/EXEC2 and waitrequest only gates holds.
  always_comb begin
    state_d  = state;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    load_req = 1'b0;
    addr_d   = pc_address;
    be_d     = BE_WORD;
    wdata_d  = '0;
    case (state)
      RST_WAIT: begin
        state_d  = FETCH;
        rd_d     = 1'b1;
        load_req = 1'b1;
        addr_d   = RESET_VECTOR;
      end
      FETCH: begin
        if (bus_done) state_d = EXEC1;
        else          rd_d    = read;
      end
      EXEC1: begin
        state_d  = EXEC2;
        rd_d     = mem_req & ~mem_we;
        wr_d     = mem_req & mem_we;
        load_req = mem_req;
        addr_d   = mem_addr;
        be_d     = mem_be;
        wdata_d  = mem_we ? mem_wdata : '0;
      end
      EXEC2: begin
        if (!(read | write) || bus_done) begin
          if (halt) begin
            state_d = HALTED;
          end else begin
            state_d  = FETCH;
            rd_d     = 1'b1;
            load_req = 1'b1;
          end
        end else begin
          rd_d = read;
          wr_d = write;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RST_WAIT;
      read        <= 1'b0;
      write       <= 1'b0;
      instr       <= '0;
      load_data   <= '0;
      fetch       <= 1'b0;
      exec1       <= 1'b0;
      exec2       <= 1'b0;
      active      <= 1'b1;
      instr_count <= '0;
    end else begin
      state  <= state_d;
      read   <= rd_d;
      write  <= wr_d;
      fetch  <= (state_d == FETCH);
      exec1  <= (state_d == EXEC1);
      exec2  <= (state_d == EXEC2);
      active <= (state_d != HALTED);
      if (state == FETCH && bus_done)
        instr <= readdata;
      if (state == EXEC2 && read && !waitrequest)
        load_data <= readdata;
      if (state == EXEC2 && state_d != EXEC2)
        instr_count <= instr_count + COUNT_W'(1);
    end
  end

  avalon_req_hold u_req_hold (
    .clk             (clk),
    .reset           (reset),
    .load            (load_req),
    .clear           (~(rd_d | wr_d)),
    .address_next    (addr_d),
    .byteenable_next (be_d),
    .writedata_next  (wdata_d),
    .address         (address),
    .byteenable      (byteenable),
    .writedata       (writedata)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program of random instructions is
// played through a wait-state memory model, results checked by a monitor.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_address = '0;
  logic        halt = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_be = '0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic [31:0] address, writedata, instr, load_data, instr_count;
  logic        read, write, fetch, exec1, exec2, active;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(RESET_VECTOR), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc_address(pc_address), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .instr(instr),
    .load_data(load_data), .fetch(fetch), .exec1(exec1), .exec2(exec2),
    .active(active), .instr_count(instr_count)
  );

  typedef struct {
    logic [31:0] pc, iw;
    int          ws_f;
    int          op;          // 0 none, 1 load, 2 store
    logic [31:0] maddr, wdata, rdata;
    logic [3:0]  be;
    int          ws_d;
  } ins_t;
  typedef struct { bit wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } bus_t;
  typedef struct { int ws; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [31:0] iw, ld, cnt; } arch_t;

  int          total = 0;
  int          bad = 0;
  bus_t        exp_bus[$];
  rsp_t        rsp_q[$];
  arch_t       arch_q[$];
  logic [31:0] ld_model, cnt_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic ins_t rand_ins();
    ins_t t;
    t.pc    = $urandom & 32'hFFFF_FFFC;
    t.iw    = $urandom;
    t.ws_f  = $urandom_range(0, 3);
    t.op    = $urandom_range(0, 2);
    t.maddr = $urandom & 32'hFFFF_FFFC;
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.be    = 4'($urandom_range(1, 15));
    t.ws_d  = $urandom_range(0, 3);
    return t;
  endfunction

  // memory model: wait states and read data per transfer, in program order
  initial begin
    rsp_t        r;
    bit          busy;
    int          wl;
    logic [31:0] rd;
    busy = 0; wl = 0; rd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; waitrequest = 1'b0; readdata = $urandom;
      end else if (read || write) begin
        if (!busy) begin
          if (rsp_q.size() > 0) r = rsp_q.pop_front();
          else r = '{0, 32'h0};
          busy = 1; wl = r.ws; rd = r.rdata;
        end
        waitrequest = (wl != 0);
        if (wl != 0) begin wl--; readdata = $urandom; end
        else begin busy = 0; readdata = rd; end
      end else begin
        busy = 0; waitrequest = 1'($urandom); readdata = $urandom;
      end
    end
  end

  // monitor
  initial begin
    bit          stall_prev, chk_next;
    logic [31:0] s_addr;
    logic [37:0] s_ctl;
    bus_t        e;
    arch_t       a;
    stall_prev = 0; chk_next = 0; s_addr = '0; s_ctl = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stall_prev = 0; chk_next = 0;
      end else begin
        check("rw_exclusive", {63'd0, read & write}, 64'd0);
        check("strobe_onehot", {62'd0, 2'($countones({fetch, exec1, exec2}) > 1)}, 64'd0);
        if (stall_prev) begin
          check("hold_addr", {32'd0, address}, {32'd0, s_addr});
          check("hold_ctl", {26'd0, byteenable, writedata, read, write}, {26'd0, s_ctl});
        end
        if (chk_next) begin
          chk_next = 0;
          check("arch_avail", arch_q.size(), 1 + (arch_q.size() > 1 ? 1 : 0));
          if (arch_q.size() > 0) begin
            a = arch_q.pop_front();
            check("load_data", {32'd0, load_data}, {32'd0, a.ld});
            check("instr_count", {32'd0, instr_count}, {32'd0, a.cnt});
          end
        end
        if (exec1 && arch_q.size() > 0)
          check("instr", {32'd0, instr}, {32'd0, arch_q[0].iw});
        if ((read || write) && !waitrequest) begin
          if (exp_bus.size() == 0) begin
            check("bus_unexpected", {63'd0, read | write}, 64'd0);
          end else begin
            e = exp_bus.pop_front();
            check("bus_dir", {62'd0, read, write}, {62'd0, !e.wr, e.wr});
            check("bus_addr", {32'd0, address}, {32'd0, e.addr});
            check("bus_be", {60'd0, byteenable}, {60'd0, e.be});
            if (e.wr) check("bus_wdata", {32'd0, writedata}, {32'd0, e.wd});
          end
        end
        if (exec2 && (!(read || write) || !waitrequest)) chk_next = 1;
        stall_prev = (read || write) && waitrequest;
        s_addr = address;
        s_ctl  = {byteenable, writedata, read, write};
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!fetch && n < 300) begin @(negedge clk); n++; end
    if (!fetch) begin
      check("fetch_timeout", {63'd0, fetch}, 64'd1);
      finish_run();
    end
  endtask

  task automatic push_fetch(input ins_t t, input logic [31:0] addr);
    rsp_q.push_back('{t.ws_f, t.iw});
    exp_bus.push_back('{1'b0, addr, 4'hF, 32'h0});
  endtask

  task automatic run_instr(input ins_t t, input bit has_nxt, input ins_t nxt);
    int n;
    wait_fetch();
    mem_req   = (t.op != 0);
    mem_we    = (t.op == 2);
    mem_addr  = t.maddr;
    mem_wdata = t.wdata;
    mem_be    = t.be;
    halt      = has_nxt ? 1'($urandom) : 1'b0;
    if (t.op != 0) begin
      rsp_q.push_back('{t.ws_d, (t.op == 1) ? t.rdata : $urandom});
      exp_bus.push_back('{(t.op == 2), t.maddr, t.be, t.wdata});
    end
    if (t.op == 1) ld_model = t.rdata;
    cnt_model = cnt_model + 1;
    arch_q.push_back('{t.iw, ld_model, cnt_model});
    n = 0;
    while (fetch && n < 300) begin @(negedge clk); n++; end
    check("fetch_len", n, t.ws_f + 1);
    check("exec1_follows", {63'd0, exec1}, 64'd1);
    halt = !has_nxt;
    if (has_nxt) begin
      pc_address = nxt.pc;
      push_fetch(nxt, nxt.pc);
    end
    @(negedge clk);
    check("exec2_follows", {63'd0, exec2}, 64'd1);
    mem_req = 1'($urandom); mem_we = 1'($urandom);
    mem_addr = $urandom; mem_wdata = $urandom; mem_be = 4'($urandom);
    n = 0;
    while (exec2 && n < 300) begin n++; @(negedge clk); end
    check("exec2_len", n, (t.op != 0) ? t.ws_d + 1 : 1);
  endtask

  task automatic run_program(input ins_t p[$]);
    ld_model = '0;
    cnt_model = '0;
    push_fetch(p[0], RESET_VECTOR);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < p.size(); i++)
      run_instr(p[i], (i + 1 < p.size()), (i + 1 < p.size()) ? p[i+1] : p[i]);
    for (int k = 0; k < 20; k++) begin
      check("halted_quiet", {58'd0, active, fetch, exec1, exec2, read, write}, 64'd0);
      @(negedge clk);
      if (k == 5) halt = 1'b0;
      mem_req = 1'b1;
      pc_address = $urandom;
    end
    check("bus_drain", exp_bus.size(), 0);
  endtask

  initial begin
    ins_t prog[$];
    ins_t t;
    pc_address = 32'h0000_0040;
    #12;
    check("rst_bus", {address, 24'd0, byteenable, 2'd0, read, write}, 64'd0);
    check("rst_wdata", {32'd0, writedata}, 64'd0);
    check("rst_regs", {instr, load_data}, 64'd0);
    check("rst_flags", {32'd0, instr_count}, 64'd0);
    check("rst_strobes", {60'd0, active, fetch, exec1, exec2}, 64'd8);

    t = rand_ins(); t.iw = 32'h24020005; t.ws_f = 0; t.op = 0; prog.push_back(t);
    t = rand_ins(); t.ws_f = 3; t.op = 0; prog.push_back(t);
    t = rand_ins(); t.op = 1; t.maddr = 32'h1000; t.ws_d = 2; t.rdata = 32'hDEADBEEF; prog.push_back(t);
    t = rand_ins(); t.op = 2; t.be = 4'b0011; t.wdata = 32'h0000ABCD; prog.push_back(t);
    for (int i = 0; i < 20; i++) prog.push_back(rand_ins());
    run_program(prog);

    // abort a stalled fetch with reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_bus.delete(); rsp_q.delete(); arch_q.delete();
    t = rand_ins(); t.ws_f = 8;
    push_fetch(t, RESET_VECTOR);
    reset = 1'b0;
    wait_fetch();
    @(negedge clk);
    @(negedge clk);
    check("stall_before_abort", {63'd0, read}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_read", {62'd0, read, write}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    exp_bus.delete(); rsp_q.delete(); arch_q.delete();
    check("abort_count", {32'd0, instr_count}, 64'd0);

    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back(rand_ins());
    run_program(prog);
    finish_run();
  end

  initial begin
    #200000;
    check("global_timeout", 64'd1, 64'd0);
    finish_run();
  end

endmodule
